sd_spi_cmd_engine: RTL and testbench

SPI-mode SD card command engine that sits directly downstream of the SD initialisation sequencer and the later block-read logic. It receives strobed requests (power-up clocks, 48-bit command with R1 response, command with R3/R7 extended response, single byte read). It serialises each request onto SPI mode 0, appends CRC7, and polls for the response. It returns the R1 byte on `out` with a one-cycle `rdy` pulse.

---
 rtl/sd_spi_cmd_engine_if.sv | 28 ++
 rtl/sd_spi_cmd_engine.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sd_spi_cmd_engine.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_cmd_engine_if.sv
// Request/response and SPI pin bundle between the SD init/read logic and the
// SPI-mode command engine.
interface sd_spi_cmd_engine_if;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        start;
  logic        start40;
  logic        init;
  logic        readit;
  logic        miso;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic [7:0]  out;
  logic [31:0] resp;
  logic        busy;
  logic        rdy;

  modport master (
    output cmd, arg, start, start40, init, readit, miso,
    input  sclk, mosi, cs_n, out, resp, busy, rdy
  );

  modport slave (
    input  cmd, arg, start, start40, init, readit, miso,
    output sclk, mosi, cs_n, out, resp, busy, rdy
  );
endinterface

// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD command engine: serialises init clocks, 48-bit commands with
// bit-serial CRC7, polls for R1 (plus optional 4-byte trailer) on SPI mode 0.
module sd_spi_cmd_engine #(
  parameter int CLKDIV     = 4,
  parameter int INIT_BYTES = 10,
  parameter int NCR_MAX    = 8
) (
  input  logic             clk,
  input  logic             rst,
  sd_spi_cmd_engine_if.slave bus
);

  localparam int MAXB  = (INIT_BYTES > NCR_MAX) ? ((INIT_BYTES > 6) ? INIT_BYTES : 6)
                                                : ((NCR_MAX > 6) ? NCR_MAX : 6);
  localparam int CNT_W = $clog2(MAXB + 1);
  localparam int DIV_W = $clog2(CLKDIV);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_INITCLK = 4'd1;
  localparam logic [3:0] S_PRE     = 4'd2;
  localparam logic [3:0] S_CMD     = 4'd3;
  localparam logic [3:0] S_POLL    = 4'd4;
  localparam logic [3:0] S_EXT     = 4'd5;
  localparam logic [3:0] S_POST    = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_READ    = 4'd8;

  logic [3:0]       state, state_n;
  logic [CNT_W-1:0] byte_cnt, cnt_n;
  logic             ext_req, ext_n;
  logic             cs_n_r, cs_n_n;
  logic [7:0]       out_r, out_n;
  logic [31:0]      resp_r, resp_n;

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic             half;
  logic [2:0]       bit_cnt;
  logic             sclk_r;
  logic             mosi_r;

  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic [39:0]      cmd_sr;
  logic [6:0]       crc;

  logic             div_end, bit_rise, bit_fall, byte_done;
  logic             load, stop, cmd_latch, cmd_shift, crc_clr;
  logic [7:0]       load_val;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign div_end   = (div_cnt == DIV_W'(CLKDIV - 1));
  assign bit_rise  = active && !half && div_end;
  assign bit_fall  = active && half && div_end;
  assign byte_done = bit_fall && (bit_cnt == 3'd7);

  // Every byte_done in a shifting state either loads the next byte or stops
  // the shifter, so consecutive bytes abut with no idle clocks.
  always_comb begin
    state_n   = state;
    cnt_n     = byte_cnt;
    ext_n     = ext_req;
    cs_n_n    = cs_n_r;
    out_n     = out_r;
    resp_n    = resp_r;
    load      = 1'b0;
    load_val  = 8'hFF;
    stop      = 1'b0;
    cmd_latch = 1'b0;
    cmd_shift = 1'b0;
    crc_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.init) begin
          state_n = S_INITCLK;
          cs_n_n  = 1'b1;
          cnt_n   = '0;
          load    = 1'b1;
        end else if (bus.start40 || bus.start) begin
          state_n   = S_PRE;
          cs_n_n    = 1'b0;
          ext_n     = bus.start40;
          cnt_n     = '0;
          load      = 1'b1;
          cmd_latch = 1'b1;
        end else if (bus.readit) begin
          state_n = S_READ;
          cs_n_n  = 1'b0;
          load    = 1'b1;
        end
      end
      S_INITCLK: begin
        if (byte_done) begin
          if (byte_cnt == CNT_W'(INIT_BYTES - 1)) begin
            state_n = S_DONE;
            stop    = 1'b1;
          end else begin
            cnt_n = byte_cnt + CNT_W'(1);
            load  = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (byte_done) begin
          state_n   = S_CMD;
          cnt_n     = '0;
          load      = 1'b1;
          load_val  = cmd_sr[39:32];
          cmd_shift = 1'b1;
          crc_clr   = 1'b1;
        end
      end
      S_CMD: begin
        if (byte_done) begin
          load = 1'b1;
          if (byte_cnt == CNT_W'(5)) begin
            state_n = S_POLL;
            cnt_n   = '0;
          end else begin
            cnt_n = byte_cnt + CNT_W'(1);
            if (byte_cnt == CNT_W'(4)) begin
              load_val = {crc, 1'b1};
            end else begin
              load_val  = cmd_sr[39:32];
              cmd_shift = 1'b1;
            end
          end
        end
      end
      S_POLL: begin
        if (byte_done) begin
          load = 1'b1;
          if (!rx_sr[7]) begin
            out_n = rx_sr;
            cnt_n = '0;
            if (ext_req) begin
              state_n = S_EXT;
            end else begin
              state_n = S_POST;
              cs_n_n  = 1'b1;
            end
          end else if (byte_cnt == CNT_W'(NCR_MAX - 1)) begin
            out_n   = 8'hFF;
            state_n = S_POST;
            cs_n_n  = 1'b1;
          end else begin
            cnt_n = byte_cnt + CNT_W'(1);
          end
        end
      end
      S_EXT: begin
        if (byte_done) begin
          load   = 1'b1;
          resp_n = {resp_r[23:0], rx_sr};
          if (byte_cnt == CNT_W'(3)) begin
            state_n = S_POST;
            cs_n_n  = 1'b1;
          end else begin
            cnt_n = byte_cnt + CNT_W'(1);
          end
        end
      end
      S_POST: begin
        if (byte_done) begin
          state_n = S_DONE;
          stop    = 1'b1;
        end
      end
      S_READ: begin
        if (byte_done) begin
          out_n   = rx_sr;
          state_n = S_DONE;
          stop    = 1'b1;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        state_n = S_IDLE;
        stop    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      ext_req  <= 1'b0;
      cs_n_r   <= 1'b1;
      out_r    <= 8'hFF;
      resp_r   <= '0;
      active   <= 1'b0;
      div_cnt  <= '0;
      half     <= 1'b0;
      bit_cnt  <= 3'd0;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b1;
    end else begin
      state    <= state_n;
      byte_cnt <= cnt_n;
      ext_req  <= ext_n;
      cs_n_r   <= cs_n_n;
      out_r    <= out_n;
      resp_r   <= resp_n;
      if (load) begin
        active  <= 1'b1;
        div_cnt <= '0;
        half    <= 1'b0;
        bit_cnt <= 3'd0;
        sclk_r  <= 1'b0;
        mosi_r  <= load_val[7];
      end else if (stop) begin
        active  <= 1'b0;
        div_cnt <= '0;
        half    <= 1'b0;
        bit_cnt <= 3'd0;
        sclk_r  <= 1'b0;
        mosi_r  <= 1'b1;
      end else if (active) begin
        if (div_end) begin
          div_cnt <= '0;
          half    <= ~half;
          sclk_r  <= ~half;
          if (half) begin
            bit_cnt <= bit_cnt + 3'd1;
            mosi_r  <= tx_sr[6];
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

  // Shift data needs no reset: every frame reloads it before use.
  always_ff @(posedge clk) begin
    if (load)
      tx_sr <= load_val;
    else if (bit_fall)
      tx_sr <= {tx_sr[6:0], 1'b1};
    if (bit_rise)
      rx_sr <= {rx_sr[6:0], bus.miso};
    if (cmd_latch)
      cmd_sr <= {2'b01, bus.cmd, bus.arg};
    else if (cmd_shift)
      cmd_sr <= {cmd_sr[31:0], 8'hFF};
    if (crc_clr)
      crc <= 7'd0;
    else if (bit_rise && state == S_CMD && byte_cnt < CNT_W'(5))
      crc <= crc7_step(crc, mosi_r);
  end

  assign bus.sclk = sclk_r;
  assign bus.mosi = mosi_r;
  assign bus.cs_n = cs_n_r;
  assign bus.out  = out_r;
  assign bus.resp = resp_r;
  assign bus.busy = (state != S_IDLE);
  assign bus.rdy  = (state == S_DONE);

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Scoreboard bench for sd_spi_cmd_engine: a card model captures mosi bytes and
// plays back miso bytes; expected frames/results come from a byte-level model.
module tb_sd_spi_cmd_engine;
  localparam int CLKDIV     = 4;
  localparam int INIT_BYTES = 10;
  localparam int NCR_MAX    = 8;
  localparam int BYTE_CYC   = 16 * CLKDIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  sd_spi_cmd_engine_if bus();

  sd_spi_cmd_engine #(.CLKDIV(CLKDIV), .INIT_BYTES(INIT_BYTES), .NCR_MAX(NCR_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  out;
    logic [31:0] resp;
    int          lat;
    int          nbytes;
    int          t0;
  } exp_t;

  exp_t        exp_q[$];
  logic [9:0]  frame_q[$];   // {cs_mixed, cs_n, byte}
  logic [7:0]  miso_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          want = 0;
  logic [7:0]  m_out = 8'hFF;
  logic [31:0] m_resp = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // CRC7 as the remainder of polynomial long division of data*x^7 by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  // Card model + monitor
  initial begin
    int         slot;
    int         bitn;
    logic [7:0] sh;
    logic       prev_sclk;
    logic       prev_rdy;
    logic       cs_first;
    logic       cs_mix;
    logic [9:0] cap_q[$];
    exp_t       e;
    logic [7:0] mb;
    logic [9:0] fe;
    slot = 0; bitn = 0; sh = 8'h0; prev_sclk = 1'b0; prev_rdy = 1'b0;
    cs_first = 1'b1; cs_mix = 1'b0;
    bus.miso = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.sclk && !prev_sclk) begin
        if (bitn == 0) begin
          cs_first = bus.cs_n;
          cs_mix   = 1'b0;
        end else if (bus.cs_n !== cs_first) begin
          cs_mix = 1'b1;
        end
        sh = {sh[6:0], bus.mosi};
        bitn++;
        if (bitn == 8) begin
          cap_q.push_back({cs_mix, cs_first, sh});
          bitn = 0;
          slot++;
        end
      end
      prev_sclk = bus.sclk;
      if (bus.rdy) begin
        check("rdy_single_cycle", {31'b0, prev_rdy}, 32'd0);
        check("busy_in_rdy", {31'b0, bus.busy}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdy: got rdy=1 expected no completion");
        end else begin
          e = exp_q.pop_front();
          check("out", {24'b0, bus.out}, {24'b0, e.out});
          check("resp", bus.resp, e.resp);
          check("latency", cyc - e.t0, e.lat);
          check("frame_bytes", cap_q.size(), e.nbytes);
          for (int i = 0; i < e.nbytes; i++) begin
            fe = frame_q.pop_front();
            if (i < cap_q.size()) check("frame_byte", {22'b0, cap_q[i]}, {22'b0, fe});
          end
        end
        done_cnt++;
        cap_q.delete();
      end
      prev_rdy = bus.rdy;
      if (!bus.busy) begin
        slot = 0;
        bitn = 0;
        cap_q.delete();
      end
      mb = (slot < miso_q.size()) ? miso_q[slot] : 8'hFF;
      bus.miso = mb[7 - bitn];
    end
  end

  task automatic push_exp(input int nb);
    exp_t e;
    e.out    = m_out;
    e.resp   = m_resp;
    e.nbytes = nb;
    e.lat    = nb * BYTE_CYC + 1;
    e.t0     = cyc;
    exp_q.push_back(e);
    want++;
  endtask

  task automatic wait_done(input bit rdy_poke);
    int budget;
    bit poked;
    budget = 4000;
    poked  = 1'b0;
    while (done_cnt < want && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (rdy_poke && !poked && bus.rdy) begin
        poked     = 1'b1;
        bus.cmd   = 6'h3F;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("strobe_in_rdy_ignored", {31'b0, bus.busy}, 32'd0);
      end
    end
    if (done_cnt < want) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d completions expected %0d", done_cnt, want);
      done_cnt = want;
    end
  endtask

  task automatic do_cmd(input bit ext, input logic [5:0] c, input logic [31:0] a,
                        input int delay, input logic [7:0] r1, input logic [31:0] xv,
                        input int crc_byte, input bit busy_poke, input bit rdy_poke);
    bit          hit;
    int          polls;
    logic [7:0]  cb;
    logic [39:0] body;
    body  = {2'b01, c, a};
    cb    = (crc_byte >= 0) ? crc_byte[7:0] : {crc7_ref(body), 1'b1};
    hit   = (delay < NCR_MAX);
    polls = hit ? delay + 1 : NCR_MAX;
    miso_q.delete();
    for (int i = 0; i < 7; i++) miso_q.push_back(8'hFF);
    if (hit) begin
      for (int i = 0; i < delay; i++) miso_q.push_back(8'hFF);
      miso_q.push_back(r1);
      if (ext) for (int k = 0; k < 4; k++) miso_q.push_back(xv[31 - 8*k -: 8]);
    end
    frame_q.push_back(10'h0FF);
    for (int k = 0; k < 5; k++) frame_q.push_back({2'b00, body[39 - 8*k -: 8]});
    frame_q.push_back({2'b00, cb});
    for (int i = 0; i < polls; i++) frame_q.push_back(10'h0FF);
    if (hit && ext) for (int k = 0; k < 4; k++) frame_q.push_back(10'h0FF);
    frame_q.push_back(10'h1FF);
    if (hit) begin
      m_out = r1;
      if (ext) m_resp = xv;
    end else begin
      m_out = 8'hFF;
    end
    @(posedge clk); #1;
    bus.cmd     = c;
    bus.arg     = a;
    bus.start40 = ext;
    bus.start   = ext ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.readit  = 1'($urandom_range(0, 1));
    push_exp(8 + polls + ((hit && ext) ? 4 : 0));
    @(posedge clk); #1;
    bus.start = 1'b0; bus.start40 = 1'b0; bus.readit = 1'b0;
    if (busy_poke) begin
      repeat (150) @(posedge clk);
      #1;
      check("busy_mid_frame", {31'b0, bus.busy}, 32'd1);
      bus.cmd = ~c; bus.arg = ~a; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    wait_done(rdy_poke);
  endtask

  task automatic do_init(input bit also_start);
    miso_q.delete();
    for (int i = 0; i < INIT_BYTES; i++) frame_q.push_back(10'h1FF);
    @(posedge clk); #1;
    bus.init  = 1'b1;
    bus.start = also_start;
    push_exp(INIT_BYTES);
    @(posedge clk); #1;
    bus.init = 1'b0; bus.start = 1'b0;
    wait_done(1'b0);
  endtask

  task automatic do_read(input logic [7:0] rb);
    miso_q.delete();
    miso_q.push_back(rb);
    frame_q.push_back(10'h0FF);
    m_out = rb;
    @(posedge clk); #1;
    bus.readit = 1'b1;
    push_exp(1);
    @(posedge clk); #1;
    bus.readit = 1'b0;
    wait_done(1'b0);
    check("cs_low_after_read", {31'b0, bus.cs_n}, 32'd0);
  endtask

  initial begin
    int kind;
    int dly;
    bus.cmd = 6'd0; bus.arg = 32'd0;
    bus.start = 1'b0; bus.start40 = 1'b0; bus.init = 1'b0; bus.readit = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("idle_cs_n", {31'b0, bus.cs_n}, 32'd1);
    check("idle_sclk", {31'b0, bus.sclk}, 32'd0);
    check("idle_mosi", {31'b0, bus.mosi}, 32'd1);
    check("idle_out", {24'b0, bus.out}, 32'h0FF);
    check("idle_resp", bus.resp, 32'h0);
    check("idle_busy", {31'b0, bus.busy}, 32'd0);
    check("idle_rdy", {31'b0, bus.rdy}, 32'd0);

    do_init(1'b0);
    do_cmd(1'b0, 6'd0,  32'h0,        1, 8'h01, 32'h0,        8'h95, 1'b0, 1'b0);
    do_cmd(1'b1, 6'd8,  32'h000001AA, 0, 8'h01, 32'h000001AA, 8'h87, 1'b0, 1'b0);
    do_cmd(1'b0, 6'd55, 32'h0,        0, 8'h01, 32'h0,        8'h65, 1'b0, 1'b0);
    do_cmd(1'b0, 6'd41, 32'h40000000, 3, 8'h00, 32'h0,        8'h77, 1'b0, 1'b0);
    do_cmd(1'b1, 6'd58, 32'h0,        2, 8'h00, 32'hC0FF8000, 8'hFD, 1'b0, 1'b0);
    do_cmd(1'b0, 6'd17, 32'h00001234, NCR_MAX, 8'h00, 32'h0,  -1,    1'b0, 1'b0);
    do_cmd(1'b1, 6'd58, 32'h0,        NCR_MAX + 1, 8'h00, 32'h0, -1, 1'b0, 1'b0);
    do_cmd(1'b0, 6'd16, 32'h00000200, 2, 8'h00, 32'h0,        -1,    1'b1, 1'b0);
    do_cmd(1'b0, 6'd13, 32'h0,        0, 8'h00, 32'h0,        -1,    1'b0, 1'b1);
    do_init(1'b1);
    do_read(8'hFE);
    do_read(8'h3C);
    do_read(8'h81);

    // Abort a command with reset while the command bytes are shifting
    miso_q.delete();
    @(posedge clk); #1;
    bus.cmd = 6'd55; bus.arg = 32'h0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    check("cs_low_before_abort", {31'b0, bus.cs_n}, 32'd0);
    check("busy_before_abort", {31'b0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort_cs_n", {31'b0, bus.cs_n}, 32'd1);
    check("abort_sclk", {31'b0, bus.sclk}, 32'd0);
    check("abort_mosi", {31'b0, bus.mosi}, 32'd1);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_rdy", {31'b0, bus.rdy}, 32'd0);
    check("abort_out", {24'b0, bus.out}, 32'h0FF);
    check("abort_resp", bus.resp, 32'h0);
    m_out  = 8'hFF;
    m_resp = 32'h0;
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (5) @(posedge clk);

    for (int n = 0; n < 20; n++) begin
      kind = $urandom_range(0, 2);
      dly  = $urandom_range(0, NCR_MAX + 1);
      if (kind == 2)
        do_read(8'($urandom));
      else
        do_cmd(kind[0], 6'($urandom), $urandom, dly, {1'b0, 7'($urandom)}, $urandom,
               -1, 1'b0, 1'b0);
    end

    repeat (20) @(posedge clk);
    #1;
    check("pending_expectations", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
